// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_ctrl
// Brief    : Instruction-fetch controller: PC sequencing, req/gnt/rvalid RAM
//            handshake, stale-response dropping after redirect, {pc,instr} FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl #(
    parameter int FIFO_DEPTH      = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] boot_addr_i,
    input  logic        fetch_en_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        busy_o
);

    localparam int c_CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_boot_done;
    logic [31:0]          r_pc_req;
    logic [31:0]          r_resp_pc;
    logic [c_CNT_W-1:0]   r_outstanding;
    logic [c_CNT_W-1:0]   r_drop_cnt;
    logic [c_CNT_W-1:0]   w_out_next;
    logic [c_FCNT_W-1:0]  r_fifo_count;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [31:0]          r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]          r_fifo_data [FIFO_DEPTH];

    logic w_req;
    logic w_fire;
    logic w_resp;
    logic w_push;
    logic w_pop;
    logic w_boot_load;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Credit covers both in-flight requests and buffered words, so every
    // granted response is guaranteed a FIFO slot.
    assign w_req = (r_state == ST_RUN)
                && (int'(r_outstanding) < MAX_OUTSTANDING)
                && ((int'(r_outstanding) + int'(r_fifo_count)) < FIFO_DEPTH)
                && !redirect_i;

    assign w_fire      = w_req && instr_gnt_i;
    assign w_resp      = instr_rvalid_i && (r_outstanding != '0);
    assign w_push      = w_resp && (r_drop_cnt == '0) && !redirect_i;
    assign w_pop       = (r_fifo_count != '0) && instr_ready_i && !redirect_i;
    assign w_boot_load = (r_state == ST_IDLE) && fetch_en_i && !r_boot_done;

    always_comb begin
        w_out_next = r_outstanding;
        case ({w_fire, w_resp})
            2'b10:   w_out_next = r_outstanding + c_CNT_W'(1);
            2'b01:   w_out_next = r_outstanding - c_CNT_W'(1);
            default: w_out_next = r_outstanding;
        endcase
    end

    // A pending ungranted request pins the FSM in RUN so req/addr stay stable.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (fetch_en_i) w_state_next = ST_RUN;
            ST_RUN:  if (!fetch_en_i && !(w_req && !instr_gnt_i)) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_IDLE;
            r_boot_done   <= 1'b0;
            r_pc_req      <= '0;
            r_resp_pc     <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_out_next;
            if ((r_state == ST_IDLE) && (w_state_next == ST_RUN))
                r_boot_done <= 1'b1;

            if (redirect_i) begin
                r_pc_req   <= {redirect_addr_i[31:2], 2'b00};
                r_resp_pc  <= {redirect_addr_i[31:2], 2'b00};
                r_drop_cnt <= w_out_next;
            end else begin
                if (w_boot_load) begin
                    r_pc_req  <= {boot_addr_i[31:2], 2'b00};
                    r_resp_pc <= {boot_addr_i[31:2], 2'b00};
                end else begin
                    if (w_fire) r_pc_req  <= r_pc_req + 32'd4;
                    if (w_push) r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_resp && (r_drop_cnt != '0))
                    r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fifo_count <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_pc[i]   <= '0;
                r_fifo_data[i] <= '0;
            end
        end else if (redirect_i) begin
            r_fifo_count <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
                r_fifo_data[r_wr_ptr] <= instr_rdata_i;
                r_wr_ptr              <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + c_FCNT_W'(1);
                2'b01:   r_fifo_count <= r_fifo_count - c_FCNT_W'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    assign instr_req_o   = w_req;
    assign instr_addr_o  = r_pc_req;
    assign instr_valid_o = (r_fifo_count != '0);
    assign instr_rdata_o = r_fifo_data[r_rd_ptr];
    assign instr_pc_o    = r_fifo_pc[r_rd_ptr];
    assign busy_o        = (r_state == ST_RUN) || (r_outstanding != '0) || (r_fifo_count != '0);

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(instr_rvalid_i && (r_outstanding == '0)))
                else $error("if_fetch_ctrl: rvalid with no outstanding request");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_ctrl
// Brief    : Randomized bench for if_fetch_ctrl against a transaction-level
//            model (queue of in-flight requests, queue of buffered words).
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_ctrl;

    localparam int c_DEPTH   = 2;
    localparam int c_MAX_OUT = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] boot_addr_i;
    logic        fetch_en_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        busy_o;

    if_fetch_ctrl #(.FIFO_DEPTH(c_DEPTH), .MAX_OUTSTANDING(c_MAX_OUT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .boot_addr_i(boot_addr_i), .fetch_en_i(fetch_en_i),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
        .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
        .instr_valid_o(instr_valid_o), .instr_rdata_o(instr_rdata_o), .instr_pc_o(instr_pc_o),
        .instr_ready_i(instr_ready_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] addr; bit stale; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } word_t;

    int     checks   = 0;
    int     failures = 0;
    bit     m_run;
    bit     m_booted;
    logic [31:0] m_pc;
    pend_t  pend[$];
    word_t  fq[$];
    bit     fe;

    function automatic logic [31:0] ram(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_booted = 0; m_pc = '0;
        pend.delete(); fq.delete();
    endtask

    // One clock cycle: drive at negedge, check, then advance the model
    // across the following posedge.
    task automatic step(input bit g, input bit rv, input bit rdy, input bit rd,
                        input logic [31:0] ra);
        bit    exp_req;
        pend_t e;
        @(negedge clk_i);
        fetch_en_i      = fe;
        instr_gnt_i     = g;
        instr_rvalid_i  = rv && (pend.size() != 0);
        instr_rdata_i   = instr_rvalid_i ? ram(pend[0].addr) : $urandom;
        instr_ready_i   = rdy;
        redirect_i      = rd;
        redirect_addr_i = ra;
        #1;
        exp_req = m_run && (pend.size() < c_MAX_OUT)
               && ((pend.size() + fq.size()) < c_DEPTH) && !rd;
        chk("req",   32'(instr_req_o),   32'(exp_req));
        chk("addr",  instr_addr_o,       m_pc);
        chk("valid", 32'(instr_valid_o), 32'(fq.size() != 0));
        chk("busy",  32'(busy_o),        32'(m_run || pend.size() != 0 || fq.size() != 0));
        if (fq.size() != 0) begin
            chk("head_pc",   instr_pc_o,    fq[0].pc);
            chk("head_data", instr_rdata_o, fq[0].data);
        end
        if (fq.size() != 0 && rdy && !rd) void'(fq.pop_front());
        if (instr_rvalid_i) begin
            e = pend.pop_front();
            if (!e.stale && !rd) fq.push_back('{e.addr, ram(e.addr)});
        end
        if (exp_req && g) begin
            pend.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (!m_run && fe) begin
            m_run = 1;
            if (!m_booted) m_pc = {boot_addr_i[31:2], 2'b00};
            m_booted = 1;
        end else if (m_run && !fe && !(exp_req && !g)) begin
            m_run = 0;
        end
        if (rd) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            fq.delete();
            m_pc = {ra[31:2], 2'b00};
        end
    endtask

    task automatic run_rand(input int n, input int gp, input int vp, input int yp, input int dp);
        for (int i = 0; i < n; i++)
            step($urandom_range(99) < gp, $urandom_range(99) < vp,
                 $urandom_range(99) < yp, $urandom_range(99) < dp, $urandom);
    endtask

    task automatic async_reset();
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        fe = 0; fetch_en_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0;
        redirect_i = 0; instr_ready_i = 0;
        #1;
        model_reset();
        chk("rst_req",   32'(instr_req_o),   0);
        chk("rst_addr",  instr_addr_o,       0);
        chk("rst_valid", 32'(instr_valid_o), 0);
        chk("rst_rdata", instr_rdata_o,      0);
        chk("rst_pc",    instr_pc_o,         0);
        chk("rst_busy",  32'(busy_o),        0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0; boot_addr_i = 32'h80; fe = 0; fetch_en_i = 0;
        instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = 0;
        redirect_i = 0; redirect_addr_i = 0; instr_ready_i = 0;
        model_reset();
        repeat (2) @(negedge clk_i);
        chk("init_req",   32'(instr_req_o),   0);
        chk("init_addr",  instr_addr_o,       0);
        chk("init_valid", 32'(instr_valid_o), 0);
        chk("init_busy",  32'(busy_o),        0);
        rst_ni = 1'b1;

        // Streaming fetch from boot address.
        fe = 1;
        run_rand(30, 100, 100, 100, 0);
        // Decode back-pressure, then release.
        run_rand(12, 100, 100, 0, 0);
        run_rand(10, 100, 100, 100, 0);
        // Build two in-flight requests, then redirect (with a misaligned target).
        run_rand(4, 100, 0, 0, 0);
        step(1, 0, 1, 1, 32'h0000_0203);
        run_rand(20, 100, 100, 100, 0);
        // Grant withheld: request must hold steady.
        run_rand(6, 0, 100, 100, 0);
        run_rand(10, 100, 100, 100, 0);
        // Address wrap at the top of the space.
        step(0, 0, 1, 1, 32'hFFFF_FFF8);
        run_rand(12, 100, 100, 100, 0);
        // Fetch disabled, then resumed at the current PC.
        fe = 0;
        run_rand(20, 70, 80, 80, 0);
        fe = 1;
        run_rand(20, 70, 80, 80, 0);
        // Random mix including redirects.
        run_rand(300, 60, 50, 60, 5);
        // Boot address is ignored until the next reset.
        boot_addr_i = 32'h0000_1000;
        run_rand(8, 100, 0, 0, 0);
        async_reset();
        fe = 1;
        run_rand(30, 100, 100, 100, 0);
        run_rand(400, 60, 50, 60, 4);
        fe = 0;
        run_rand(30, 80, 80, 80, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
